// File: rtl/div_seq_ctrl_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    localparam int DW = 16;
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_e;

    typedef logic [DW-1:0] div_data_t;

    // Magnitude of an operand: two's-complement absolute value when signed,
    // raw bits otherwise. The most negative value maps to its own bit pattern,
    // which is the correct unsigned magnitude.
    function automatic div_data_t absVal(input div_data_t v, input logic signedOp);
        return (signedOp && v[DW-1]) ? div_data_t'(-v) : v;
    endfunction

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Handshake and data bundle between the operand source and the divider.
interface div_seq_ctrl_if;
    import div_pkg::*;

    logic      start;
    logic      sign_mode;
    div_data_t dividend;
    div_data_t divisor;
    logic      busy;
    logic      done;
    div_data_t quotient;
    div_data_t remainder;
    logic      div_by_zero;

    modport master (
        output start, sign_mode, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, sign_mode, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_seq_ctrl_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference only when it is non-negative.
module div_step
    import div_pkg::*;
(
    input  div_data_t rem,
    input  logic      next_bit,
    input  div_data_t dvs,
    output div_data_t rem_next,
    output logic      q_bit
);

    logic [DW:0] w_remSh;
    logic [DW:0] w_trial;

    // Trial subtraction; the extra MSB of the difference is its sign.
    always_comb begin
        w_remSh  = {rem, next_bit};
        w_trial  = w_remSh - {1'b0, dvs};
        q_bit    = ~w_trial[DW];
        rem_next = q_bit ? w_trial[DW-1:0] : w_remSh[DW-1:0];
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencer for the iterative restoring divider: operand capture, one quotient
// bit per clock MSB first, sign fix-up and divide-by-zero handling.
module div_seq_ctrl
    import div_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    div_seq_ctrl_if.slave bus
);

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    div_state_e      r_state;
    logic [CW-1:0]   r_count;
    div_data_t       r_dvd;
    div_data_t       r_dvs;
    div_data_t       r_rem;
    logic [DW-2:0]   r_quo;
    logic            r_negQuo;
    logic            r_negRem;
    logic            r_busy;
    logic            r_done;
    div_data_t       r_quotient;
    div_data_t       r_remainder;
    logic            r_dbz;

    logic            w_dvdBit;
    div_data_t       w_remNext;
    logic            w_qBit;
    div_data_t       w_quoRaw;
    div_data_t       w_quoFinal;
    div_data_t       w_remFinal;

    assign w_dvdBit = r_dvd[r_count];

    div_step u_step (
        .rem      (r_rem),
        .next_bit (w_dvdBit),
        .dvs      (r_dvs),
        .rem_next (w_remNext),
        .q_bit    (w_qBit)
    );

    // Result of the final step with the operand signs applied; the
    // remainder follows the dividend's sign, negating zero leaves it zero.
    always_comb begin
        w_quoRaw   = {r_quo, w_qBit};
        w_quoFinal = r_negQuo ? div_data_t'(-w_quoRaw) : w_quoRaw;
        w_remFinal = r_negRem ? div_data_t'(-w_remNext) : w_remNext;
    end

    // Controller FSM with the counter, datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_negQuo    <= 1'b0;
            r_negRem    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_busy <= 1'b1;
                        if (bus.divisor == '0) begin
                            r_quotient  <= '1;
                            r_remainder <= bus.dividend;
                            r_dbz       <= 1'b1;
                            r_done      <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_dvd    <= absVal(bus.dividend, bus.sign_mode);
                            r_dvs    <= absVal(bus.divisor, bus.sign_mode);
                            r_negQuo <= bus.sign_mode & (bus.dividend[DW-1] ^ bus.divisor[DW-1]);
                            r_negRem <= bus.sign_mode & bus.dividend[DW-1];
                            r_rem    <= '0;
                            r_quo    <= '0;
                            r_count  <= CNT_LAST;
                            r_dbz    <= 1'b0;
                            r_state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_rem <= w_remNext;
                    r_quo <= {r_quo[DW-3:0], w_qBit};
                    if (r_count == '0) begin
                        r_quotient  <= w_quoFinal;
                        r_remainder <= w_remFinal;
                        r_done      <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_count <= r_count - CNT_ONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;

endmodule
